hpu_ctrl_regs: RTL and testbench
================================

HPU_CTRL_REGS -- requirements
Module: hpu_ctrl_regs

Interface
REQ-001 SHALL have parameter NCORE, default 8, number of cores driven by core_en (1..16).
REQ-002 SHALL have parameter AW_I, default 20, width of addr_i/addr_j.
REQ-003 SHALL have parameter IW, default 16, width of item_num/mat_a.
REQ-004 SHALL use one clock and an asynchronous active-low reset: ports S_AXI_ACLK and S_AXI_ARESETN.
REQ-005 SHALL have ports, one per line:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  async active-low reset
- S_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY  AXI-Lite write channel  32/1/1, 32/4/1/1, 2/1/1
- S_AXI_ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  AXI-Lite read channel  32/1/1, 32/2/1/1
- mat_a  in  IW  item-memory write index from the datapath
- done_in  in  1  one-cycle pulse: final output beat accepted
- matw, run, last  out  1 each  mode bits to the datapath
- addr_i, addr_j  out  AW_I  loop bounds
- item_num  out  IW  last item-memory index
- core_en  out  NCORE  per-core enable
- irq  out  1  level interrupt

Function
REQ-006 SHALL implement the AXI-Lite slave FSM INI, AW, W, AWW, AR1, AR2: AWREADY=INI|W, WREADY=INI|AW, ARREADY=INI, BVALID=AWW, RVALID=AR2, BRESP=RRESP=00.
REQ-007 SHALL, in INI, give write priority (AW&W -> AWW; AW -> AW; W -> W) over read (AR -> AR1); AWW->INI on BREADY; AR1->AR2 unconditionally; AR2->INI on RREADY.
REQ-008 SHALL decode offset ADDR[7:2] only; register write occurs in the AWW cycle of entry and honours WSTRB per byte.
REQ-009 SHALL map: 0x00 CTRL {last,run,matw} bits[2:0] RW; 0x04 STATUS RO {matw_done,done,busy} bits[2:0]; 0x08 ADDR_I RW; 0x0C ADDR_J RW; 0x10 SCRATCH RW 32b; 0x14 ITEM_NUM RW; 0x18 CORE_EN RW; 0x1C IRQ_EN RW bits[1:0]; 0x20 IRQ_STAT W1C bits[1:0] {matw_done,done}; 0x24 INFO RO {NCORE[7:0] at 15:8, version 8'h02 at 7:0}; 0x28 CYCLES RO.
REQ-010 SHALL return 0 on reads of unmapped offsets and unused bits; unmapped writes SHALL be ignored with OKAY.
REQ-011 SHALL latch RDATA in AR1 and hold it stable through AR2.
REQ-012 SHALL clear matw the cycle after matw=1 and mat_a==item_num, and set IRQ_STAT.matw_done.
REQ-013 SHALL, on done_in while run=1, clear run and set IRQ_STAT.done; done_in while run=0 SHALL be ignored.
REQ-014 SHALL drive busy = run|matw.
REQ-015 SHALL clear CYCLES on a CTRL write taking run 0->1 and increment it each cycle run=1, saturating at 0xFFFF_FFFF.
REQ-016 SHALL drive irq = |(IRQ_STAT & IRQ_EN), registered, one-cycle latency.
REQ-017 SHALL give a simultaneous CTRL write priority over auto-clear of matw/run.
REQ-018 SHALL give a simultaneous set event priority over a W1C clear of the same IRQ_STAT bit.
REQ-019 SHALL mask CORE_EN writes to NCORE bits; all mode/bound outputs are direct register outputs (no combinational path from AXI inputs).

Reset
REQ-020 SHALL, on S_AXI_ARESETN low, asynchronously reset FSM to INI, matw/run/last/irq to 0, IRQ_EN/IRQ_STAT/CYCLES/SCRATCH to 0, ADDR_I=7, ADDR_J=2, ITEM_NUM=99, CORE_EN=all ones, RDATA=0.
REQ-021 SHALL, on reset mid-transaction, drop BVALID/RVALID immediately and discard the pending write.

Structure
REQ-022 SHALL take register offsets, FSM state encodings, version constant and reset defaults from shared package hpu_pkg.
REQ-023 SHALL contain one sub-module, hpu_axil_fsm (channel FSM plus address/data capture); the register file stays in hpu_ctrl_regs.

Verification
REQ-024 Reset then read 0x08/0x0C/0x14/0x24 -> 7, 2, 99, 0x0000_0802 (NCORE=8).
REQ-025 AW at cycle 0, W at cycle 3 to 0x14 data 0x0000_0004, WSTRB=0001 -> AWW one cycle later, BVALID held until BREADY; readback 4.
REQ-026 Write CTRL=1, IRQ_EN=2, drive mat_a 0..4 with ITEM_NUM=4 -> matw falls the cycle after mat_a=4, IRQ_STAT=2, irq high one cycle later.
REQ-027 Write CTRL=2, wait 10 cycles, pulse done_in -> run=0, CYCLES=10 or 11 per REQ-015 counting, STATUS=0b010.
REQ-028 W1C to IRQ_STAT bit0 in the same cycle as done_in -> bit0 remains 1.
REQ-029 Assert reset during AR2 with RREADY low -> RVALID low same cycle, FSM in INI, next read succeeds.

Source files
------------

// File: rtl/hpu_pkg.sv
// Shared constants and helpers for the HPU control register block: channel FSM
// state encodings, register word offsets, version and reset defaults.
package hpu_pkg;

  // AXI-Lite slave channel states.
  typedef enum logic [2:0] {
    ST_INI = 3'd0,  // idle, all address/data channels ready
    ST_AW  = 3'd1,  // write address taken, waiting for write data
    ST_W   = 3'd2,  // write data taken, waiting for write address
    ST_AWW = 3'd3,  // both taken: register write, then hold BVALID
    ST_AR1 = 3'd4,  // read address taken, latch read data
    ST_AR2 = 3'd5   // hold RVALID until RREADY
  } axil_state_e;

  // Register word offsets (byte address bits [7:2]).
  localparam logic [5:0] OFF_CTRL     = 6'h00;
  localparam logic [5:0] OFF_STATUS   = 6'h01;
  localparam logic [5:0] OFF_ADDR_I   = 6'h02;
  localparam logic [5:0] OFF_ADDR_J   = 6'h03;
  localparam logic [5:0] OFF_SCRATCH  = 6'h04;
  localparam logic [5:0] OFF_ITEM_NUM = 6'h05;
  localparam logic [5:0] OFF_CORE_EN  = 6'h06;
  localparam logic [5:0] OFF_IRQ_EN   = 6'h07;
  localparam logic [5:0] OFF_IRQ_STAT = 6'h08;
  localparam logic [5:0] OFF_INFO     = 6'h09;
  localparam logic [5:0] OFF_CYCLES   = 6'h0A;

  localparam logic [7:0] HPU_VERSION = 8'h02;

  // Reset defaults of the loop-bound registers.
  localparam int RST_ADDR_I   = 7;
  localparam int RST_ADDR_J   = 2;
  localparam int RST_ITEM_NUM = 99;

  // Merge a 32-bit write into an existing value, byte lane by byte lane.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hpu_ctrl_regs_if.sv
// AXI-Lite bundle between the host bus and the HPU control registers.
interface hpu_ctrl_regs_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/hpu_axil_fsm.sv
// AXI-Lite slave channel FSM: captures write address/data and read address,
// issues a one-cycle register write strobe on entry to AWW and latches read
// data in AR1 so RDATA stays stable while RVALID is held.
module hpu_axil_fsm
  import hpu_pkg::*;
(
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  hpu_ctrl_regs_if.slave    axi,
  input  logic [31:0]       rd_data,
  output logic              wr_en,
  output logic [5:0]        wr_off,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  output logic [5:0]        rd_off
);

  axil_state_e state;
  logic [31:0] rdata_q;

  // Only the word offset is decoded; the remaining address bits are ignored.
  wire unused_addr_bits = ^{axi.S_AXI_AWADDR[31:8], axi.S_AXI_AWADDR[1:0],
                            axi.S_AXI_ARADDR[31:8], axi.S_AXI_ARADDR[1:0]};

  // Channel state, capture registers and the write strobe.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state   <= ST_INI;
      wr_en   <= 1'b0;
      wr_off  <= '0;
      wr_data <= '0;
      wr_strb <= '0;
      rd_off  <= '0;
      rdata_q <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_INI: begin
          if (axi.S_AXI_AWVALID && axi.S_AXI_WVALID) begin
            wr_off  <= axi.S_AXI_AWADDR[7:2];
            wr_data <= axi.S_AXI_WDATA;
            wr_strb <= axi.S_AXI_WSTRB;
            wr_en   <= 1'b1;
            state   <= ST_AWW;
          end else if (axi.S_AXI_AWVALID) begin
            wr_off <= axi.S_AXI_AWADDR[7:2];
            state  <= ST_AW;
          end else if (axi.S_AXI_WVALID) begin
            wr_data <= axi.S_AXI_WDATA;
            wr_strb <= axi.S_AXI_WSTRB;
            state   <= ST_W;
          end else if (axi.S_AXI_ARVALID) begin
            rd_off <= axi.S_AXI_ARADDR[7:2];
            state  <= ST_AR1;
          end
        end
        ST_AW: begin
          if (axi.S_AXI_WVALID) begin
            wr_data <= axi.S_AXI_WDATA;
            wr_strb <= axi.S_AXI_WSTRB;
            wr_en   <= 1'b1;
            state   <= ST_AWW;
          end
        end
        ST_W: begin
          if (axi.S_AXI_AWVALID) begin
            wr_off <= axi.S_AXI_AWADDR[7:2];
            wr_en  <= 1'b1;
            state  <= ST_AWW;
          end
        end
        ST_AWW: if (axi.S_AXI_BREADY) state <= ST_INI;
        ST_AR1: begin
          rdata_q <= rd_data;
          state   <= ST_AR2;
        end
        ST_AR2: if (axi.S_AXI_RREADY) state <= ST_INI;
        default: state <= ST_INI;
      endcase
    end
  end

  // Handshake outputs decode the state register only.
  assign axi.S_AXI_AWREADY = (state == ST_INI) || (state == ST_W);
  assign axi.S_AXI_WREADY  = (state == ST_INI) || (state == ST_AW);
  assign axi.S_AXI_ARREADY = (state == ST_INI);
  assign axi.S_AXI_BVALID  = (state == ST_AWW);
  assign axi.S_AXI_RVALID  = (state == ST_AR2);
  assign axi.S_AXI_BRESP   = 2'b00;
  assign axi.S_AXI_RRESP   = 2'b00;
  assign axi.S_AXI_RDATA   = rdata_q;

endmodule

// File: rtl/hpu_ctrl_regs.sv
// HPU control/status register file behind an AXI-Lite slave: mode bits and
// loop bounds for the datapath, matw/run auto-clear, run cycle counter and a
// maskable level interrupt.
module hpu_ctrl_regs
  import hpu_pkg::*;
#(
  parameter int NCORE = 8,
  parameter int AW_I  = 20,
  parameter int IW    = 16
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  hpu_ctrl_regs_if.slave    s_axi,
  input  logic [IW-1:0]     mat_a,
  input  logic              done_in,
  output logic              matw,
  output logic              run,
  output logic              last,
  output logic [AW_I-1:0]   addr_i,
  output logic [AW_I-1:0]   addr_j,
  output logic [IW-1:0]     item_num,
  output logic [NCORE-1:0]  core_en,
  output logic              irq
);

  logic        wr_en;
  logic [5:0]  wr_off;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [5:0]  rd_off;
  logic [31:0] rd_data;

  logic [31:0] scratch;
  logic [1:0]  irq_en;
  logic [1:0]  irq_stat;   // {matw_done, done}
  logic [31:0] cycles;

  hpu_axil_fsm u_fsm (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .axi           (s_axi),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_off        (wr_off),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .rd_off        (rd_off)
  );

  // Datapath completion events.
  logic matw_evt, done_evt, w1c_irq;
  assign matw_evt = matw && (mat_a == item_num);
  assign done_evt = done_in && run;
  assign w1c_irq  = wr_en && (wr_off == OFF_IRQ_STAT) && wr_strb[0];

  // Control and configuration registers; a bus write is applied after the
  // auto-clear so a simultaneous CTRL write wins.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      matw     <= 1'b0;
      run      <= 1'b0;
      last     <= 1'b0;
      addr_i   <= AW_I'(RST_ADDR_I);
      addr_j   <= AW_I'(RST_ADDR_J);
      item_num <= IW'(RST_ITEM_NUM);
      core_en  <= '1;
      scratch  <= '0;
      irq_en   <= '0;
      cycles   <= '0;
    end else begin
      if (matw_evt) matw <= 1'b0;
      if (done_evt) run  <= 1'b0;
      if (run && (cycles != '1)) cycles <= cycles + 32'd1;

      if (wr_en) begin
        case (wr_off)
          OFF_CTRL: begin
            if (wr_strb[0]) begin
              matw <= wr_data[0];
              run  <= wr_data[1];
              last <= wr_data[2];
              if (!run && wr_data[1]) cycles <= '0;
            end
          end
          OFF_ADDR_I:   addr_i   <= AW_I'(apply_strb(32'(addr_i), wr_data, wr_strb));
          OFF_ADDR_J:   addr_j   <= AW_I'(apply_strb(32'(addr_j), wr_data, wr_strb));
          OFF_SCRATCH:  scratch  <= apply_strb(scratch, wr_data, wr_strb);
          OFF_ITEM_NUM: item_num <= IW'(apply_strb(32'(item_num), wr_data, wr_strb));
          OFF_CORE_EN:  core_en  <= NCORE'(apply_strb(32'(core_en), wr_data, wr_strb));
          OFF_IRQ_EN:   if (wr_strb[0]) irq_en <= wr_data[1:0];
          default: ;
        endcase
      end
    end
  end

  // Sticky interrupt status (set beats W1C) and the registered interrupt line.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      irq_stat <= (irq_stat & ~(w1c_irq ? wr_data[1:0] : 2'b00)) | {matw_evt, done_evt};
      irq      <= |(irq_stat & irq_en);
    end
  end

  // Read mux, sampled by the FSM in AR1.
  // NOTE: rd_data is given a default before the case so unmapped offsets
  // read as zero and no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (rd_off)
      OFF_CTRL:     rd_data = {29'd0, last, run, matw};
      OFF_STATUS:   rd_data = {29'd0, irq_stat[1], irq_stat[0], run | matw};
      OFF_ADDR_I:   rd_data = 32'(addr_i);
      OFF_ADDR_J:   rd_data = 32'(addr_j);
      OFF_SCRATCH:  rd_data = scratch;
      OFF_ITEM_NUM: rd_data = 32'(item_num);
      OFF_CORE_EN:  rd_data = 32'(core_en);
      OFF_IRQ_EN:   rd_data = {30'd0, irq_en};
      OFF_IRQ_STAT: rd_data = {30'd0, irq_stat};
      OFF_INFO:     rd_data = {16'd0, 8'(NCORE), HPU_VERSION};
      OFF_CYCLES:   rd_data = cycles;
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_hpu_ctrl_regs.sv
// Directed testbench for hpu_ctrl_regs with hand-computed expected values.
module tb_hpu_ctrl_regs;

  localparam int NCORE = 8;
  localparam int AW_I  = 20;
  localparam int IW    = 16;

  localparam int INJ_NONE = 0;
  localparam int INJ_DONE = 1;  // pulse done_in during the AWW write cycle
  localparam int INJ_MAT  = 2;  // drive mat_a=4 during the AWW write cycle

  logic             S_AXI_ACLK = 1'b0;
  logic             S_AXI_ARESETN;
  logic [IW-1:0]    mat_a;
  logic             done_in;
  logic             matw, run, last, irq;
  logic [AW_I-1:0]  addr_i, addr_j;
  logic [IW-1:0]    item_num;
  logic [NCORE-1:0] core_en;

  int n_checks = 0;
  int n_fail   = 0;

  hpu_ctrl_regs_if axi ();

  hpu_ctrl_regs #(.NCORE(NCORE), .AW_I(AW_I), .IW(IW)) dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .s_axi         (axi),
    .mat_a         (mat_a),
    .done_in       (done_in),
    .matw          (matw),
    .run           (run),
    .last          (last),
    .addr_i        (addr_i),
    .addr_j        (addr_j),
    .item_num      (item_num),
    .core_en       (core_en),
    .irq           (irq)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge S_AXI_ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int inject);
    int n;
    bit aw_hs, w_hs, aw_done, w_done;
    axi.S_AXI_AWADDR  = a;
    axi.S_AXI_WDATA   = d;
    axi.S_AXI_WSTRB   = s;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    axi.S_AXI_BREADY  = 1'b0;
    aw_done = 0;
    w_done  = 0;
    n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_hs  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      tick();
      n++;
      if (aw_hs) begin axi.S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_hs)  begin axi.S_AXI_WVALID  = 1'b0; w_done  = 1; end
    end
    if (!(aw_done && w_done)) begin
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
      check("wr_addr_data_timeout", 32'd0, 32'd1);
    end else begin
      if (inject == INJ_DONE) done_in = 1'b1;
      if (inject == INJ_MAT)  mat_a   = 16'd4;
      if (inject != INJ_NONE) begin
        tick();
        done_in = 1'b0;
        mat_a   = '0;
      end
      n = 0;
      while (!axi.S_AXI_BVALID && n < 20) begin tick(); n++; end
      if (!axi.S_AXI_BVALID) begin
        check("wr_resp_timeout", 32'd0, 32'd1);
      end else begin
        check("bresp", 32'(axi.S_AXI_BRESP), 32'd0);
        axi.S_AXI_BREADY = 1'b1;
        tick();
        axi.S_AXI_BREADY = 1'b0;
      end
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    bit hs, ar_done;
    axi.S_AXI_ARADDR  = a;
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_RREADY  = 1'b0;
    ar_done = 0;
    n = 0;
    d = 32'hDEAD_BEEF;
    while (!ar_done && n < 20) begin
      hs = axi.S_AXI_ARVALID && axi.S_AXI_ARREADY;
      tick();
      n++;
      if (hs) begin axi.S_AXI_ARVALID = 1'b0; ar_done = 1; end
    end
    if (!ar_done) begin
      axi.S_AXI_ARVALID = 1'b0;
      check("rd_addr_timeout", 32'd0, 32'd1);
    end else begin
      n = 0;
      while (!axi.S_AXI_RVALID && n < 20) begin tick(); n++; end
      if (!axi.S_AXI_RVALID) begin
        check("rd_data_timeout", 32'd0, 32'd1);
      end else begin
        d = axi.S_AXI_RDATA;
        check("rresp", 32'(axi.S_AXI_RRESP), 32'd0);
        axi.S_AXI_RREADY = 1'b1;
        tick();
        axi.S_AXI_RREADY = 1'b0;
      end
    end
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    axi_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic apply_reset();
    S_AXI_ARESETN = 1'b0;
    repeat (3) tick();
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
    tick();
  endtask

  initial begin
    S_AXI_ARESETN     = 1'b0;
    mat_a             = '0;
    done_in           = 1'b0;
    axi.S_AXI_AWADDR  = '0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = '0;
    axi.S_AXI_WSTRB   = '0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b0;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_mode", {29'd0, last, run, matw}, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_addr_i", 32'(addr_i), 32'd7);
    check("rst_addr_j", 32'(addr_j), 32'd2);
    check("rst_item_num", 32'(item_num), 32'd99);
    check("rst_core_en", 32'(core_en), 32'h0000_00FF);
    check("rst_valids", {30'd0, axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 32'd0);
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
    tick();

    // Reset readback
    rd_check("rd_addr_i", 32'h08, 32'd7);
    rd_check("rd_addr_j", 32'h0C, 32'd2);
    rd_check("rd_item_num", 32'h14, 32'd99);
    rd_check("rd_info", 32'h24, 32'h0000_0802);
    rd_check("rd_status_idle", 32'h04, 32'd0);
    rd_check("rd_unmapped", 32'h3C, 32'd0);

    // AW at cycle 0, W at cycle 3, BREADY held off
    axi.S_AXI_AWADDR  = 32'h14;
    axi.S_AXI_AWVALID = 1'b1;
    check("awready_ini", 32'(axi.S_AXI_AWREADY), 32'd1);
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    check("awready_in_aw", 32'(axi.S_AXI_AWREADY), 32'd0);
    check("wready_in_aw", 32'(axi.S_AXI_WREADY), 32'd1);
    tick();
    tick();
    axi.S_AXI_WDATA  = 32'h0000_0004;
    axi.S_AXI_WSTRB  = 4'b0001;
    axi.S_AXI_WVALID = 1'b1;
    tick();
    axi.S_AXI_WVALID = 1'b0;
    check("bvalid_aww", 32'(axi.S_AXI_BVALID), 32'd1);
    check("readies_aww", {29'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 32'd0);
    tick();
    check("item_num_written", 32'(item_num), 32'd4);
    tick();
    tick();
    check("bvalid_hold", 32'(axi.S_AXI_BVALID), 32'd1);
    axi.S_AXI_BREADY = 1'b1;
    tick();
    axi.S_AXI_BREADY = 1'b0;
    check("bvalid_drop", 32'(axi.S_AXI_BVALID), 32'd0);
    rd_check("rd_item_num_4", 32'h14, 32'd4);

    // Byte strobes, width masking, unmapped writes
    axi_write(32'h10, 32'hAABB_CCDD, 4'hF, INJ_NONE);
    axi_write(32'h10, 32'h1122_3344, 4'b0101, INJ_NONE);
    rd_check("scratch_wstrb", 32'h10, 32'hAA22_CC44);
    axi_write(32'h3C, 32'hFFFF_FFFF, 4'hF, INJ_NONE);
    check("unmapped_wr_ignored", 32'(addr_i), 32'd7);
    axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, INJ_NONE);
    rd_check("addr_i_width", 32'h08, 32'h000F_FFFF);
    axi_write(32'h18, 32'hFFFF_0F0F, 4'hF, INJ_NONE);
    check("core_en_mask", 32'(core_en), 32'h0000_000F);
    rd_check("rd_core_en", 32'h18, 32'h0000_000F);

    // matw auto-clear and matw_done interrupt
    axi_write(32'h1C, 32'd2, 4'hF, INJ_NONE);
    axi_write(32'h00, 32'd1, 4'hF, INJ_NONE);
    check("matw_set", 32'(matw), 32'd1);
    for (int k = 0; k < 5; k++) begin
      mat_a = IW'(k);
      check("matw_before_match", 32'(matw), 32'd1);
      tick();
    end
    mat_a = '0;
    check("matw_autoclear", 32'(matw), 32'd0);
    check("irq_latency", 32'(irq), 32'd0);
    tick();
    check("irq_set", 32'(irq), 32'd1);
    rd_check("irq_stat_matw", 32'h20, 32'd2);
    rd_check("status_matw_done", 32'h04, 32'd4);
    axi_write(32'h20, 32'd2, 4'hF, INJ_NONE);
    rd_check("irq_stat_w1c", 32'h20, 32'd0);
    check("irq_cleared", 32'(irq), 32'd0);

    // run with done_in and the cycle counter
    axi_write(32'h00, 32'd2, 4'hF, INJ_NONE);
    check("run_set", 32'(run), 32'd1);
    repeat (9) tick();
    check("run_hold", 32'(run), 32'd1);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    check("run_done_clear", 32'(run), 32'd0);
    rd_check("status_done", 32'h04, 32'd2);
    rd_check("cycles_count", 32'h28, 32'd10);
    rd_check("irq_stat_done", 32'h20, 32'd1);
    check("irq_masked", 32'(irq), 32'd0);

    // done_in while idle is ignored
    axi_write(32'h20, 32'd1, 4'hF, INJ_NONE);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    rd_check("done_ignored_idle", 32'h20, 32'd0);

    // Set beats simultaneous W1C of the same bit
    axi_write(32'h00, 32'd2, 4'hF, INJ_NONE);
    axi_write(32'h20, 32'd1, 4'hF, INJ_DONE);
    check("run_cleared_w1c", 32'(run), 32'd0);
    rd_check("set_beats_w1c", 32'h20, 32'd1);

    // CTRL write beats simultaneous matw auto-clear
    axi_write(32'h20, 32'd3, 4'hF, INJ_NONE);
    axi_write(32'h00, 32'd1, 4'hF, INJ_NONE);
    axi_write(32'h00, 32'd5, 4'hF, INJ_MAT);
    check("ctrl_beats_autoclear", {30'd0, last, matw}, 32'd3);
    rd_check("matw_done_still_set", 32'h20, 32'd2);
    mat_a = 16'd4;
    tick();
    mat_a = '0;
    check("matw_clear_after", 32'(matw), 32'd0);

    // Reset during AWW discards the write and drops BVALID at once
    axi.S_AXI_AWADDR  = 32'h10;
    axi.S_AXI_WDATA   = 32'h1234_5678;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    check("bvalid_pre_rst", 32'(axi.S_AXI_BVALID), 32'd1);
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b0;
    #1;
    check("bvalid_rst_drop", 32'(axi.S_AXI_BVALID), 32'd0);
    repeat (2) tick();
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
    tick();
    rd_check("write_discarded", 32'h10, 32'd0);

    // Reset during AR2 with RREADY low
    axi.S_AXI_ARADDR  = 32'h24;
    axi.S_AXI_ARVALID = 1'b1;
    tick();
    axi.S_AXI_ARVALID = 1'b0;
    check("rvalid_ar1", 32'(axi.S_AXI_RVALID), 32'd0);
    tick();
    check("rvalid_ar2", 32'(axi.S_AXI_RVALID), 32'd1);
    check("rdata_ar2", axi.S_AXI_RDATA, 32'h0000_0802);
    tick();
    check("rdata_stable", axi.S_AXI_RDATA, 32'h0000_0802);
    S_AXI_ARESETN = 1'b0;
    #1;
    check("rvalid_rst_drop", 32'(axi.S_AXI_RVALID), 32'd0);
    check("arready_rst_ini", 32'(axi.S_AXI_ARREADY), 32'd1);
    apply_reset();
    rd_check("rd_after_rst", 32'h24, 32'h0000_0802);
    rd_check("item_num_after_rst", 32'h14, 32'd99);
    check("core_en_after_rst", 32'(core_en), 32'h0000_00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
